// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   fwa_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   STAT_W      : width of the optional statistics counters
//   sat_inc     : saturating increment used by the statistics counters
// Optional feature macro used by the arbiter: FWA_STATS_EN
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fwa_state_e;

    localparam int STAT_W = 16;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The search starts one position
// after rr_ptr and wraps modulo NUM_REQ; the first eligible requester wins.
// Ports:
//   eligible [NUM_REQ] : requesters that may be granted this cycle
//   rr_ptr   [IDX_W]   : index of the most recently served requester
//   winner   [IDX_W]   : selected requester (rr_ptr when nothing is eligible)
//   any                : at least one requester is eligible
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    // cand[k] is the requester index examined at search position k.
    logic [IDX_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            // One extra bit so rr_ptr + (gi+1) cannot overflow before the wrap.
            assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi + 1);
            assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                              IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(sum);
            assign rot[gi] = eligible[cand[gi]];
        end
    endgenerate

    // Walk from the far end so the nearest eligible position is written last.
    always_comb begin
        winner = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                winner = cand[k];
            end
        end
    end

    assign any = |eligible;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the single FIFO write port among NUM_REQ
// producers. A winner's word is captured at the pick, written with a one-cycle
// fifo_wr_en, and the FIFO's registered wr_ack/overflow response is checked one
// cycle later. Success pulses done[winner]; overflow (or no response) retries
// the same word up to MAX_RETRY times, after which err[winner] pulses.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req [NUM_REQ]       : level requests, held until done/err
//   req_data            : requester i word in [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt [NUM_REQ]       : one-hot grant during the ISSUE cycle
//   done/err [NUM_REQ]  : one-cycle completion / drop pulses
//   fifo_wr_en, fifo_data_in : FIFO write side
//   fifo_full, fifo_wr_ack, fifo_overflow : FIFO status inputs
//   stat_wr_cnt, stat_ovf_cnt : saturating counters (only with FWA_STATS_EN)
// Optional feature macro: FWA_STATS_EN
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow
`ifdef FWA_STATS_EN
    ,
    output logic [STAT_W-1:0]             stat_wr_cnt,
    output logic [STAT_W-1:0]             stat_ovf_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int RC_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    fwa_state_e             state_reg, state_next;
    logic [IDX_W-1:0]       winner_reg, winner_next;
    logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [RC_W-1:0]        retry_cnt_reg, retry_cnt_next;
    logic [DATA_WIDTH-1:0]  data_reg, data_next;
    logic                   wr_en_reg, wr_en_next;
    logic [NUM_REQ-1:0]     gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]     done_reg, done_next;
    logic [NUM_REQ-1:0]     err_reg, err_next;

    logic [NUM_REQ-1:0]     eligible;
    logic [IDX_W-1:0]       pick_winner;
    logic                   pick_any;
    logic                   resp_fail;
    logic                   retry_ok;
    logic                   retry_pend;
    logic [DATA_WIDTH-1:0]  req_word [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // A requester seeing its own done/err pulse still has req high for this
    // cycle; masking it stops the same word from being written twice.
    assign eligible   = req & ~done_reg & ~err_reg;
    // Overflow and "no response" are treated alike; wr_ack overrides both.
    assign resp_fail  = fifo_overflow | ~fifo_wr_ack;
    assign retry_ok   = retry_cnt_reg < RC_W'(MAX_RETRY);
    // A non-zero retry count means the latched word is waiting to be reissued.
    assign retry_pend = retry_cnt_reg != '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_reg),
        .winner   (pick_winner),
        .any      (pick_any)
    );

    always_comb begin
        state_next     = state_reg;
        winner_next    = winner_reg;
        rr_ptr_next    = rr_ptr_reg;
        retry_cnt_next = retry_cnt_reg;
        data_next      = data_reg;
        wr_en_next     = 1'b0;
        gnt_next       = '0;
        done_next      = '0;
        err_next       = '0;
        case (state_reg)
            IDLE: begin
                if (!fifo_full) begin
                    if (retry_pend) begin
                        // Retry owns the port regardless of current requests.
                        wr_en_next           = 1'b1;
                        gnt_next[winner_reg] = 1'b1;
                        state_next           = ISSUE;
                    end else if (pick_any) begin
                        winner_next           = pick_winner;
                        data_next             = req_word[pick_winner];
                        wr_en_next            = 1'b1;
                        gnt_next[pick_winner] = 1'b1;
                        state_next            = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                state_next = IDLE;
                if (fifo_wr_ack) begin
                    done_next[winner_reg] = 1'b1;
                    rr_ptr_next           = winner_reg;
                    retry_cnt_next        = '0;
                end else if (resp_fail) begin
                    if (retry_ok) begin
                        retry_cnt_next = retry_cnt_reg + RC_W'(1);
                    end else begin
                        err_next[winner_reg] = 1'b1;
                        rr_ptr_next          = winner_reg;
                        retry_cnt_next       = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            winner_reg    <= '0;
            rr_ptr_reg    <= IDX_W'(NUM_REQ - 1);
            retry_cnt_reg <= '0;
            data_reg      <= '0;
            wr_en_reg     <= 1'b0;
            gnt_reg       <= '0;
            done_reg      <= '0;
            err_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            winner_reg    <= winner_next;
            rr_ptr_reg    <= rr_ptr_next;
            retry_cnt_reg <= retry_cnt_next;
            data_reg      <= data_next;
            wr_en_reg     <= wr_en_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign fifo_wr_en   = wr_en_reg;
    assign fifo_data_in = data_reg;
    assign gnt          = gnt_reg;
    assign done         = done_reg;
    assign err          = err_reg;

`ifdef FWA_STATS_EN
    logic [STAT_W-1:0] stat_wr_cnt_reg;
    logic [STAT_W-1:0] stat_ovf_cnt_reg;
    logic              wr_inc;
    logic              ovf_inc;

    // Same decisions the FSM makes in WAIT; only real overflows are counted
    // as overflow retries, silent (no-response) retries are not.
    assign wr_inc  = (state_reg == WAIT) && fifo_wr_ack;
    assign ovf_inc = (state_reg == WAIT) && !fifo_wr_ack && fifo_overflow && retry_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_cnt_reg  <= '0;
            stat_ovf_cnt_reg <= '0;
        end else begin
            if (wr_inc) begin
                stat_wr_cnt_reg <= sat_inc(stat_wr_cnt_reg);
            end
            if (ovf_inc) begin
                stat_ovf_cnt_reg <= sat_inc(stat_ovf_cnt_reg);
            end
        end
    end

    assign stat_wr_cnt  = stat_wr_cnt_reg;
    assign stat_ovf_cnt = stat_ovf_cnt_reg;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the synchronous FIFO among `NUM_REQ` producers. It captures one requester's word, issues a one-cycle `wr_en`, and checks the FIFO's registered `wr_ack`/`overflow` response. It returns a per-requester `done` pulse on success and retries on overflow. It sits between the producer agents and the FIFO write side. The FIFO read side is untouched.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be 2 to 16.
- `DATA_WIDTH`, default 16: FIFO word width.
- `MAX_RETRY`, default 3: overflow retries allowed per word before it is dropped.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, `NUM_REQ`: level request per producer, held until its `done` or `err` pulse.
- `req_data`, in, `NUM_REQ*DATA_WIDTH`: word of requester i in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`, out, `NUM_REQ`: one-hot, high during the ISSUE cycle of the current winner.
- `done`, out, `NUM_REQ`: one-cycle pulse; that requester's word was accepted by the FIFO.
- `err`, out, `NUM_REQ`: one-cycle pulse; that requester's word was dropped after `MAX_RETRY` retries.
- `fifo_wr_en`, out, 1: FIFO write enable.
- `fifo_data_in`, out, `DATA_WIDTH`: FIFO write data.
- `fifo_full`, in, 1: FIFO full flag.
- `fifo_wr_ack`, in, 1: FIFO registered write acknowledge.
- `fifo_overflow`, in, 1: FIFO registered overflow flag.
- `stat_wr_cnt`, out, 16: successful-write count; present only when `FWA_STATS_EN` is defined.
- `stat_ovf_cnt`, out, 16: overflow-retry count; present only when `FWA_STATS_EN` is defined.

## Operation
- States are IDLE, ISSUE and WAIT.
- **IDLE**
  - If `|eligible` and `!fifo_full`, pick a winner and go to ISSUE.
  - `eligible` is `req & ~done & ~err`. This masks a requester that is seeing its own completion pulse, which prevents a double write.
  - When the pick is made: latch the winner index, register `fifo_data_in = req_data[winner]`, set `fifo_wr_en=1` and `gnt=onehot(winner)`.
  - If `fifo_full` is high, stay in IDLE and issue nothing.
- **ISSUE** (one cycle)
  - `fifo_wr_en` is high for this cycle only.
  - Next state is WAIT; `fifo_wr_en` and `gnt` clear at that transition.
- **WAIT** (one cycle): sample the FIFO response.
  - `fifo_wr_ack=1`: pulse `done[winner]` next cycle, advance `rr_ptr` to winner, clear `retry_cnt`, go to IDLE.
  - `fifo_overflow=1` or no response, with `retry_cnt < MAX_RETRY`: increment `retry_cnt`, keep `winner` and the latched data, go to IDLE.
    - The retry has absolute priority on the next pick, even if `req[winner]` has dropped.
  - Same condition with `retry_cnt == MAX_RETRY`: pulse `err[winner]`, advance `rr_ptr`, clear `retry_cnt`, go to IDLE.
  - If `wr_ack` and `overflow` are both high, `wr_ack` wins.
- **Round-robin rule:** search starts at `(rr_ptr+1) mod NUM_REQ`; first eligible requester wins. `rr_ptr` resets to `NUM_REQ-1`, so `req[0]` has first priority.
- **Data capture:** data is captured at the pick. Requester data changing afterwards has no effect.
- **Dropped request:** a requester dropping `req` mid-transfer still gets `done` or `err`.
- **Reset** (asynchronous, any state):
  - State returns to IDLE.
  - All outputs go to 0: `fifo_wr_en`, `fifo_data_in`, `gnt`, `done`, `err`, and the stat counters.
  - `retry_cnt` goes to 0 and `rr_ptr` to `NUM_REQ-1`.
  - An in-flight word is abandoned with no `done` or `err`.

## Timing
- Cycle 0: IDLE, pick made.
- Cycle 1: ISSUE, `fifo_wr_en=1`.
- Cycle 2: WAIT, `wr_ack` or `overflow` visible.
- Cycle 3: `done` or `err` pulse; IDLE may pick a new winner in the same cycle.
- Sustained throughput is one write per 3 cycles.
- `req` to `fifo_wr_en` latency is 1 cycle.
- All outputs are registered; there is no combinational path from `req` or `fifo_*` to outputs.

## Configuration
- `FWA_STATS_EN` defined:
  - `stat_wr_cnt` increments on each `done`.
  - `stat_ovf_cnt` increments on each overflow retry.
  - Both are 16-bit and saturate at 16'hFFFF.
- `FWA_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Package `fifo_arb_pkg`:
  - `fwa_state_e` enum (IDLE, ISSUE, WAIT).
  - `STAT_W = 16`.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `eligible`, `rr_ptr`.
  - Outputs: `winner` index and `any`.

## Test plan
- **Single request:** `req=4'b0010`, data 16'hA5A5, FIFO empty -> `fifo_wr_en` in cycle 1 with `fifo_data_in=16'hA5A5`, `gnt=4'b0010`, `done=4'b0010` in cycle 3.
- **Round-robin order:** `req=4'b1111` held -> grant order 0,1,2,3,0; every `done` is single; no requester is written twice per `done`.
- **Full gating:** `fifo_full=1` with `req` pending -> `fifo_wr_en` stays 0; release full -> write issues the next cycle.
- **Overflow retry:** model returns `overflow` 2 times, then `wr_ack` -> same winner reissued 3 times with the same data, one `done`, and `stat_ovf_cnt=2` with `FWA_STATS_EN`.
- **Drop after retries:** `overflow` forced every time with `MAX_RETRY=3` -> 4 writes, then `err[winner]` pulse, pointer advances to the next requester.
- **Reset mid-transfer:** assert `rst_n=0` during ISSUE -> all outputs 0 immediately, no `done`; after release, `req[0]` wins first.
